// File: rtl/matrix_byte_loader.sv
// matrix_byte_loader: parses a UART byte stream (slot, m, n, m*n hi/lo elements) into
// matrix_mem dimension and element writes. Define LOADER_CHECKSUM_EN for a trailing XOR byte.
module matrix_byte_loader #(
   parameter int MAX_DIM     = 5,
   parameter int WR_SLOT_MAX = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic        abort,
   output logic [1:0]  user_slot_idx,
   output logic [2:0]  user_row,
   output logic [2:0]  user_col,
   output logic [15:0] user_data,
   output logic        user_we,
   output logic [2:0]  user_dim_m,
   output logic [2:0]  user_dim_n,
   output logic        user_dim_we,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam logic [7:0] DIM_MAX_B  = 8'(MAX_DIM);
   localparam logic [7:0] SLOT_MAX_B = 8'(WR_SLOT_MAX);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [3:0] {
      S_SLOT = 4'd0,
      S_M    = 4'd1,
      S_N    = 4'd2,
      S_DIM  = 4'd3,
      S_HI   = 4'd4,
      S_LO   = 4'd5,
      S_CHK  = 4'd6,
      S_DONE = 4'd7,
      S_ERR  = 4'd8
   } state_t;
`else
   typedef enum logic [3:0] {
      S_SLOT = 4'd0,
      S_M    = 4'd1,
      S_N    = 4'd2,
      S_DIM  = 4'd3,
      S_HI   = 4'd4,
      S_LO   = 4'd5,
      S_DONE = 4'd7,
      S_ERR  = 4'd8
   } state_t;
`endif

   state_t      state_r;
   logic [1:0]  slot_r;
   logic [2:0]  m_r;
   logic [2:0]  n_r;
   logic [2:0]  row_r;
   logic [2:0]  col_r;
   logic [7:0]  hi_r;
   logic        accept_s;
   logic        last_col_s;
   logic        last_elem_s;
   logic [2:0]  row_nxt_s;
   logic [2:0]  col_nxt_s;

   // Dimension bytes are judged on all 8 bits so 8'h0B is rejected rather than truncated.
   function automatic logic dim_legal(input logic [7:0] b);
      return (b != 8'd0) && (b <= DIM_MAX_B);
   endfunction

   function automatic logic slot_legal(input logic [7:0] b);
      return b <= SLOT_MAX_B;
   endfunction

   assign accept_s = in_valid & in_ready & ~abort;

   // Row-major successor of the current element coordinate and last-element detection
   always_comb begin
      last_col_s  = (col_r == (n_r - 3'd1));
      last_elem_s = last_col_s && (row_r == (m_r - 3'd1));
      if (last_col_s) begin
         col_nxt_s = 3'd0;
         row_nxt_s = row_r + 3'd1;
      end else begin
         col_nxt_s = col_r + 3'd1;
         row_nxt_s = row_r;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] cks_r;

   function automatic logic [7:0] cks_next(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   // Running XOR of every accepted frame byte, restarted by the slot byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cks_r <= 8'd0;
      end else if (accept_s) begin
         if (state_r == S_SLOT) begin
            cks_r <= in_data;
         end else if (state_r != S_CHK) begin
            cks_r <= cks_next(cks_r, in_data);
         end
      end
   end
`endif

   // Frame parser FSM; every output is a register updated here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= S_SLOT;
         in_ready      <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         user_we       <= 1'b0;
         user_dim_we   <= 1'b0;
         user_slot_idx <= 2'd0;
         user_row      <= 3'd0;
         user_col      <= 3'd0;
         user_data     <= 16'd0;
         user_dim_m    <= 3'd0;
         user_dim_n    <= 3'd0;
         slot_r        <= 2'd0;
         m_r           <= 3'd0;
         n_r           <= 3'd0;
         row_r         <= 3'd0;
         col_r         <= 3'd0;
         hi_r          <= 8'd0;
      end else begin
         user_we     <= 1'b0;
         user_dim_we <= 1'b0;
         done        <= 1'b0;
         if (abort) begin
            // Cancel wins over a same-cycle byte; error is left as it stands.
            state_r  <= S_SLOT;
            in_ready <= 1'b1;
            busy     <= 1'b0;
         end else begin
            case (state_r)
               S_SLOT: begin
                  if (accept_s) begin
                     if (slot_legal(in_data)) begin
                        slot_r  <= in_data[1:0];
                        error   <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= S_M;
                     end else begin
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                        state_r  <= S_ERR;
                     end
                  end
               end
               S_M: begin
                  if (accept_s) begin
                     if (dim_legal(in_data)) begin
                        m_r     <= in_data[2:0];
                        state_r <= S_N;
                     end else begin
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                        state_r  <= S_ERR;
                     end
                  end
               end
               S_N: begin
                  if (accept_s) begin
                     if (dim_legal(in_data)) begin
                        n_r           <= in_data[2:0];
                        user_dim_we   <= 1'b1;
                        user_dim_m    <= m_r;
                        user_dim_n    <= in_data[2:0];
                        user_slot_idx <= slot_r;
                        in_ready      <= 1'b0;
                        state_r       <= S_DIM;
                     end else begin
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                        state_r  <= S_ERR;
                     end
                  end
               end
               S_DIM: begin
                  row_r    <= 3'd0;
                  col_r    <= 3'd0;
                  in_ready <= 1'b1;
                  state_r  <= S_HI;
               end
               S_HI: begin
                  if (accept_s) begin
                     hi_r    <= in_data;
                     state_r <= S_LO;
                  end
               end
               S_LO: begin
                  if (accept_s) begin
                     user_we   <= 1'b1;
                     user_row  <= row_r;
                     user_col  <= col_r;
                     user_data <= {hi_r, in_data};
                     row_r     <= row_nxt_s;
                     col_r     <= col_nxt_s;
                     if (last_elem_s) begin
`ifdef LOADER_CHECKSUM_EN
                        state_r <= S_CHK;
`else
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                        state_r  <= S_DONE;
`endif
                     end else begin
                        state_r <= S_HI;
                     end
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               S_CHK: begin
                  if (accept_s) begin
                     busy     <= 1'b0;
                     in_ready <= 1'b0;
                     if (in_data == cks_r) begin
                        done    <= 1'b1;
                        state_r <= S_DONE;
                     end else begin
                        error   <= 1'b1;
                        state_r <= S_ERR;
                     end
                  end
               end
`endif
               S_DONE: begin
                  in_ready <= 1'b1;
                  state_r  <= S_SLOT;
               end
               S_ERR: begin
                  in_ready <= 1'b1;
                  state_r  <= S_SLOT;
               end
               default: begin
                  busy     <= 1'b0;
                  in_ready <= 1'b1;
                  state_r  <= S_SLOT;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_matrix_byte_loader.sv
// Self-checking bench for matrix_byte_loader: directed frames plus random frames checked
// against a frame-level reference model (honours LOADER_CHECKSUM_EN when defined).
`timescale 1ns/1ps
module tb_matrix_byte_loader;
   localparam int MAX_DIM     = 5;
   localparam int WR_SLOT_MAX = 1;

   typedef logic [7:0] bytes_t[$];

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        abort = 1'b0;
   logic        in_ready;
   logic [1:0]  user_slot_idx;
   logic [2:0]  user_row;
   logic [2:0]  user_col;
   logic [15:0] user_data;
   logic        user_we;
   logic [2:0]  user_dim_m;
   logic [2:0]  user_dim_n;
   logic        user_dim_we;
   logic        busy;
   logic        done;
   logic        error;

   int n_assert = 0;
   int n_fail   = 0;

   matrix_byte_loader #(.MAX_DIM(MAX_DIM), .WR_SLOT_MAX(WR_SLOT_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .abort(abort), .user_slot_idx(user_slot_idx), .user_row(user_row), .user_col(user_col),
      .user_data(user_data), .user_we(user_we), .user_dim_m(user_dim_m), .user_dim_n(user_dim_n),
      .user_dim_we(user_dim_we), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // Monitor: outputs of posedge k and the transfer due at posedge k+1 share tag bookkeeping
   int          cyc = 0;
   logic [21:0] mon_wr[$];
   int          mon_wr_tag[$];
   logic [7:0]  mon_dim[$];
   int          mon_dim_tag[$];
   int          mon_done_tag[$];
   int          xfer_tag[$];

   always begin
      @(negedge clk);
      #2;
      cyc++;
      if (user_we) begin
         mon_wr.push_back({user_row, user_col, user_data});
         mon_wr_tag.push_back(cyc);
      end
      if (user_dim_we) begin
         mon_dim.push_back({user_slot_idx, user_dim_m, user_dim_n});
         mon_dim_tag.push_back(cyc);
      end
      if (done) mon_done_tag.push_back(cyc);
      if (in_valid && in_ready && !abort) xfer_tag.push_back(cyc + 1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      mon_wr.delete(); mon_wr_tag.delete(); mon_dim.delete(); mon_dim_tag.delete();
      mon_done_tag.delete(); xfer_tag.delete();
   endtask

   // Drive one byte from a negedge; returns at the negedge after it was taken.
   task automatic send_byte(input logic [7:0] b, input bit gaps, input string tag);
      int budget = 0;
      if (gaps) begin
         repeat ($urandom_range(2, 0)) begin
            in_data = 8'($urandom);
            @(negedge clk);
         end
      end
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 20) check({tag, ":ready_timeout"}, 32'(budget), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   function automatic bytes_t add_cks(input bytes_t f);
      bytes_t r = f;
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] x = 8'd0;
      foreach (f[i]) x ^= f[i];
      r.push_back(x);
`endif
      return r;
   endfunction

   function automatic bytes_t rand_frame();
      bytes_t f;
      int m = $urandom_range(MAX_DIM, 1);
      int n = $urandom_range(MAX_DIM, 1);
      f.push_back(8'($urandom_range(WR_SLOT_MAX, 0)));
      f.push_back(8'(m));
      f.push_back(8'(n));
      for (int k = 0; k < 2 * m * n; k++) f.push_back(8'($urandom));
      return add_cks(f);
   endfunction

   // Send a frame and compare the observed strobes with the frame-level model.
   task automatic run_frame(input bytes_t f, input bit gaps, input bit do_abort, input string tag);
      logic [21:0] exp_wr[$];
      bit          exp_dim = 1'b0;
      bit          exp_err = 1'b0;
      bit          exp_done = 1'b0;
      int          total = 0;
      int          nel = 0;
      int          n = 1;
      logic [7:0]  x = 8'd0;
      if (f[0] > WR_SLOT_MAX) exp_err = 1'b1;
      else if (f[1] == 8'd0 || f[1] > MAX_DIM) exp_err = 1'b1;
      else if (f[2] == 8'd0 || f[2] > MAX_DIM) exp_err = 1'b1;
      else begin
         exp_dim = 1'b1;
         n       = int'(f[2]);
         total   = int'(f[1]) * n;
         nel     = (f.size() - 3) / 2;
         if (nel > total) nel = total;
         for (int k = 0; k < nel; k++)
            exp_wr.push_back({3'(k / n), 3'(k % n), f[3 + 2 * k], f[4 + 2 * k]});
         if (!do_abort) begin
`ifdef LOADER_CHECKSUM_EN
            for (int i = 0; i < 3 + 2 * total; i++) x ^= f[i];
            if (x == f[3 + 2 * total]) exp_done = 1'b1;
            else exp_err = 1'b1;
`else
            exp_done = 1'b1;
`endif
         end
      end

      clear_mon();
      foreach (f[i]) begin
         send_byte(f[i], gaps, tag);
         if (i == 0) check({tag, ":err_after_slot"}, 32'(error), 32'(f[0] > WR_SLOT_MAX));
      end
      if (do_abort) begin
         check({tag, ":busy_before_abort"}, 32'(busy), 32'd1);
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         abort    = 1'b1;
         @(negedge clk);
         abort    = 1'b0;
         in_valid = 1'b0;
         check({tag, ":busy_after_abort"}, 32'(busy), 32'd0);
      end
      repeat (4) @(negedge clk);

      check({tag, ":xfer_count"}, 32'(xfer_tag.size()), 32'(f.size()));
      check({tag, ":dim_count"}, 32'(mon_dim.size()), 32'(exp_dim));
      if (exp_dim && mon_dim.size() == 1) begin
         check({tag, ":dim_fields"}, 32'(mon_dim[0]), 32'({f[0][1:0], f[1][2:0], f[2][2:0]}));
         if (xfer_tag.size() > 2) check({tag, ":dim_latency"}, 32'(mon_dim_tag[0]), 32'(xfer_tag[2]));
      end
      check({tag, ":we_count"}, 32'(mon_wr.size()), 32'(exp_wr.size()));
      if (mon_wr.size() == exp_wr.size()) begin
         foreach (exp_wr[k]) begin
            check($sformatf("%s:we%0d", tag, k), 32'(mon_wr[k]), 32'(exp_wr[k]));
            if (xfer_tag.size() > 4 + 2 * k)
               check($sformatf("%s:we%0d_latency", tag, k), 32'(mon_wr_tag[k]), 32'(xfer_tag[4 + 2 * k]));
         end
      end
      check({tag, ":done_count"}, 32'(mon_done_tag.size()), 32'(exp_done));
      if (exp_done && mon_done_tag.size() == 1 && xfer_tag.size() == f.size())
         check({tag, ":done_latency"}, 32'(mon_done_tag[0]), 32'(xfer_tag[f.size() - 1]));
      check({tag, ":error"}, 32'(error), 32'(exp_err));
      check({tag, ":busy_idle"}, 32'(busy), 32'd0);
      check({tag, ":ready_idle"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      bytes_t f;
      // Reset state
      #12;
      check("rst:in_ready", 32'(in_ready), 32'd1);
      check("rst:strobes", 32'({user_we, user_dim_we, busy, done, error}), 32'd0);
      check("rst:fields", 32'({user_slot_idx, user_row, user_col, user_data, user_dim_m, user_dim_n}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 2x2 directed frame
      f = '{8'h00, 8'h02, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04};
      run_frame(add_cks(f), 1'b0, 1'b0, "t1_2x2");

      // Illegal slot, then a legal 1x1 frame clears error on its slot byte
      f = '{8'h02};
      run_frame(f, 1'b0, 1'b0, "t2_bad_slot");
      f = '{8'h01, 8'h01, 8'h01, 8'hAB, 8'hCD};
      run_frame(add_cks(f), 1'b0, 1'b0, "t2_1x1");

      // Illegal dimensions, including ones that would be legal if truncated
      f = '{8'h01, 8'h03, 8'h06};
      run_frame(f, 1'b0, 1'b0, "t3_n6");
      f = '{8'h01, 8'h00};
      run_frame(f, 1'b0, 1'b0, "t3_m0");
      f = '{8'h00, 8'h0B};
      run_frame(f, 1'b0, 1'b0, "t3_m0b");
      f = '{8'h81};
      run_frame(f, 1'b0, 1'b0, "t3_slot81");
      f = '{8'h00, 8'h05, 8'h05};
      for (int k = 0; k < 50; k++) f.push_back(8'($urandom));
      run_frame(add_cks(f), 1'b0, 1'b0, "t3_5x5");

      // 3x2 frame with in_valid toggling
      f = '{8'h01, 8'h03, 8'h02};
      for (int k = 0; k < 12; k++) f.push_back(8'($urandom));
      run_frame(add_cks(f), 1'b1, 1'b0, "t4_3x2_gaps");

      // Abort mid-frame, then a clean 1x1 frame
      f = '{8'h00, 8'h02, 8'h03};
      for (int k = 0; k < 5; k++) f.push_back(8'($urandom));
      run_frame(f, 1'b0, 1'b1, "t5_abort");
      f = '{8'h00, 8'h01, 8'h01, 8'h5A, 8'hA5};
      run_frame(add_cks(f), 1'b0, 1'b0, "t5_after");

      // Asynchronous reset mid-frame
      clear_mon();
      f = '{8'h00, 8'h01, 8'h01, 8'h12};
      foreach (f[i]) send_byte(f[i], 1'b0, "t7_rst");
      #1 rst_n = 1'b0;
      #1;
      check("t7_rst:async_busy", 32'(busy), 32'd0);
      check("t7_rst:async_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("t7_rst:no_strobe", 32'(mon_wr.size() + mon_done_tag.size()), 32'd0);
      f = '{8'h01, 8'h01, 8'h01, 8'h77, 8'h88};
      run_frame(add_cks(f), 1'b0, 1'b0, "t7_after");

      // Random legal frames
      for (int r = 0; r < 6; r++) begin
         f = rand_frame();
         run_frame(f, r[0], 1'b0, $sformatf("rand%0d", r));
      end

`ifdef LOADER_CHECKSUM_EN
      // Checksum match and mismatch
      f = '{8'h00, 8'h01, 8'h01, 8'h12, 8'h34};
      run_frame(add_cks(f), 1'b0, 1'b0, "t6_cks_ok");
      f.push_back(8'h00);
      run_frame(f, 1'b0, 1'b0, "t6_cks_bad");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
